// File: rtl/dbg_run_ctrl.sv
// Multi-core debug run control: per-core halt / N-cycle step / resume with glitch-free clock gating.
// Latency: a strobe at rising edge k updates halted at edge k; the first affected dbg_clk edge is k+1.
// Backpressure: none; strobes are always accepted. Optional PC breakpoint under DBG_BREAKPOINT_EN.
module dbg_run_ctrl #(
    parameter int NUM_CORES = 2,
    parameter int STEP_W    = 8,
    parameter int PC_W      = 32
) (
    input  logic                      sys_clk,
    input  logic                      dbg_rst,
    input  logic [NUM_CORES-1:0]      core_sel,
    input  logic                      cmd_halt,
    input  logic                      cmd_step,
    input  logic                      cmd_resume,
    input  logic [STEP_W-1:0]         step_count,
`ifdef DBG_BREAKPOINT_EN
    input  logic [NUM_CORES*PC_W-1:0] core_pc,
    input  logic [PC_W-1:0]           bp_addr,
    input  logic                      bp_arm,
    output logic [NUM_CORES-1:0]      bp_hit,
`endif
    output logic [NUM_CORES-1:0]      dbg_clk,
    output logic [NUM_CORES-1:0]      halted,
    output logic [NUM_CORES-1:0]      step_done
);

    typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_t;

    logic [NUM_CORES-1:0] bp_match;

`ifdef DBG_BREAKPOINT_EN
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_bp
        assign bp_match[gi] = bp_arm && (core_pc[gi*PC_W +: PC_W] == bp_addr);
    end
`else
    // PC_W plays no role without breakpoints; this is a constant-zero vector.
    assign bp_match = {NUM_CORES{PC_W == 0}};
`endif

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        state_t             state;
        logic [STEP_W-1:0]  cnt;
        logic               clk_en;
        logic               gate;
        logic               halted_q;
        logic               done_q;
        logic               hlt_cmd;
        logic               stp_cmd;
        logic               res_cmd;
        logic               hlt_any;

        assign hlt_cmd = core_sel[gi] & cmd_halt;
        assign stp_cmd = core_sel[gi] & cmd_step & (step_count != '0);
        assign res_cmd = core_sel[gi] & cmd_resume;
        assign hlt_any = hlt_cmd | bp_match[gi];

        always_ff @(posedge sys_clk or negedge dbg_rst) begin
            if (!dbg_rst) begin
                state    <= S_RUN;
                cnt      <= '0;
                clk_en   <= 1'b1;
                halted_q <= 1'b0;
                done_q   <= 1'b0;
`ifdef DBG_BREAKPOINT_EN
                bp_hit[gi] <= 1'b0;
`endif
            end else begin
                done_q <= 1'b0;
                case (state)
                    S_RUN: begin
                        if (hlt_any) begin
                            state    <= S_HALT;
                            clk_en   <= 1'b0;
                            halted_q <= 1'b1;
`ifdef DBG_BREAKPOINT_EN
                            if (bp_match[gi]) bp_hit[gi] <= 1'b1;
`endif
                        end
                    end
                    S_HALT: begin
                        // A halt strobe outranks step/resume even though it changes nothing here.
                        if (!hlt_cmd && stp_cmd) begin
                            state    <= S_STEP;
                            clk_en   <= 1'b1;
                            halted_q <= 1'b0;
                            cnt      <= step_count - 1'b1;
`ifdef DBG_BREAKPOINT_EN
                            bp_hit[gi] <= 1'b0;
`endif
                        end else if (!hlt_cmd && res_cmd) begin
                            state    <= S_RUN;
                            clk_en   <= 1'b1;
                            halted_q <= 1'b0;
`ifdef DBG_BREAKPOINT_EN
                            bp_hit[gi] <= 1'b0;
`endif
                        end
                    end
                    S_STEP: begin
                        if (hlt_any) begin
                            state    <= S_HALT;
                            clk_en   <= 1'b0;
                            halted_q <= 1'b1;
`ifdef DBG_BREAKPOINT_EN
                            if (bp_match[gi]) bp_hit[gi] <= 1'b1;
`endif
                        end else if (res_cmd) begin
                            state <= S_RUN;
                        end else if (cnt == '0) begin
                            state    <= S_HALT;
                            clk_en   <= 1'b0;
                            halted_q <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state    <= S_RUN;
                        clk_en   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                endcase
            end
        end

        // Gate changes only while sys_clk is low, so the AND below cannot glitch.
        always_ff @(negedge sys_clk or negedge dbg_rst) begin
            if (!dbg_rst) gate <= 1'b1;
            else          gate <= clk_en;
        end

        assign dbg_clk[gi]   = sys_clk & gate;
        assign halted[gi]    = halted_q;
        assign step_done[gi] = done_q;
    end

endmodule

// File: doc/dbg_run_ctrl.md
# dbg_run_ctrl

Multi-core debug run-control unit in the `sys_clk` domain. It generalises the single-core halt/step/resume controller to `NUM_CORES` independently gated core clocks and adds multi-cycle stepping of `STEP_W`-bit length with a completion strobe. An optional PC-match breakpoint is also available. It sits behind the JTAG-to-`sys_clk` strobe synchronisers: every command input is a one-`sys_clk`-cycle strobe.

## Interface
- `NUM_CORES`, default 2: number of independently controlled cores / gated clocks.
- `STEP_W`, default 8: width of the step-count field; max step = 2^STEP_W−1 cycles.
- `PC_W`, default 32: core PC width. Used only with `DBG_BREAKPOINT_EN`.
- `sys_clk`  in  1  free-running system clock; all state changes on its rising edge.
- `dbg_rst`  in  1  reset, asynchronous, active-low.
- `core_sel`  in  NUM_CORES  target mask for the command strobes.
- `cmd_halt`  in  1  strobe: halt selected cores.
- `cmd_step`  in  1  strobe: step selected halted cores by `step_count` cycles.
- `cmd_resume`  in  1  strobe: resume selected halted/stepping cores.
- `step_count`  in  STEP_W  cycle count, sampled with `cmd_step`.
- `dbg_clk`  out  NUM_CORES  gated core clocks: `sys_clk & gate[i]`.
- `halted`  out  NUM_CORES  registered; 1 while core i is in HALT.
- `step_done`  out  NUM_CORES  one-cycle pulse when a step completes naturally.
- `core_pc`  in  NUM_CORES*PC_W  core i PC at bits [i*PC_W +: PC_W]. Only with `DBG_BREAKPOINT_EN`.
- `bp_addr`  in  PC_W  breakpoint address. Only with `DBG_BREAKPOINT_EN`.
- `bp_arm`  in  1  level: breakpoint enabled. Only with `DBG_BREAKPOINT_EN`.
- `bp_hit`  out  NUM_CORES  sticky: core halted by breakpoint. Only with `DBG_BREAKPOINT_EN`.

## Operation
- Per-core FSM: RUN, HALT, STEP. Each core also has a `clk_en[i]` register and a `STEP_W`-bit down-counter `cnt[i]`.
- `gate[i]` is captured from `clk_en[i]` on the falling edge of `sys_clk`, giving glitch-free gating.
- Commands apply only to cores with `core_sel[i]=1`. Strobes are decoded per core each cycle.
- **RUN**
  - `halt` or breakpoint match: go to HALT, `clk_en`=0.
  - `step` and `resume` are ignored.
- **HALT**
  - `halt`: no-op.
  - `step` with `step_count=N≠0`: go to STEP, `clk_en`=1, `cnt`=N−1.
  - `step` with `N=0`: no-op, no `step_done` pulse.
  - `resume`: go to RUN, `clk_en`=1.
- **STEP**
  - `halt` or breakpoint: go to HALT, `clk_en`=0, no `step_done` (abort).
  - `resume`: go to RUN, `clk_en` stays 1.
  - `step`: ignored.
  - `cnt=0`: go to HALT, `clk_en`=0, `step_done` pulses 1 cycle.
  - Otherwise `cnt` decrements.
- Simultaneous strobes on one core: halt/breakpoint > step > resume.
- Reset, including mid-step: all cores go to RUN, `clk_en`=1, `cnt`=0, `step_done`=0, `halted`=0, `bp_hit`=0. `gate` resets to 1.

## Timing
- A command strobe sampled at rising edge k updates `clk_en` at edge k and `gate` at falling edge k. The first affected `dbg_clk` edge is rising edge k+1.
- Halt latency: `dbg_clk[i]` has no rising edge from k+1 onward. `halted[i]`=1 from edge k.
- Step of N: exactly N `dbg_clk[i]` rising edges, at k+1 … k+N.
  - `halted[i]`=0 during edges k … k+N−1.
  - At edge k+N: `halted[i]` returns to 1 and `step_done[i]` is high for that one cycle.
- Resume: `dbg_clk` pulses from k+1 onward.
- Breakpoint match is evaluated combinationally against `core_pc` at edge k, with the same latency as `cmd_halt`.

## Configuration
- Macro `DBG_BREAKPOINT_EN`.
- **Defined:**
  - `core_pc`, `bp_addr`, `bp_arm` and `bp_hit` exist.
  - In RUN or STEP, `bp_arm && core_pc[i]==bp_addr` acts as a halt for core i and sets `bp_hit[i]`.
  - `bp_hit[i]` clears on an accepted step or resume to core i, or on reset.
- **Undefined:** those ports are absent; no comparators are built; behaviour is otherwise identical.

## Test plan
- Reset, then idle 5 cycles -> `halted`=0, `dbg_clk`=`sys_clk` on all cores, `step_done`=0.
- `cmd_halt`, `core_sel`=2'b01 -> core0 `dbg_clk` stops at next edge and `halted`=2'b01; core1 keeps toggling.
- Core0 halted, `cmd_step`, `step_count`=3 -> exactly 3 `dbg_clk[0]` pulses, then `step_done[0]` for 1 cycle and `halted[0]`=1. Repeating with `step_count`=0 gives no pulses and no `step_done`.
- `step_count`=200, `cmd_halt` after 10 pulses -> exactly 10 pulses, `halted[0]`=1, no `step_done`. Same-cycle `cmd_halt`+`cmd_resume` -> HALT.
- `dbg_rst` low during a 50-cycle step -> immediate RUN, `dbg_clk` ungated from the first edge after release.
- `DBG_BREAKPOINT_EN`: `bp_arm`=1, `bp_addr`=0x100, core1 PC reaches 0x100 -> `halted[1]` and `bp_hit[1]` next edge; `cmd_resume` clears `bp_hit[1]`.
